// File: rtl/add_pipe_pkg.sv
// Shared types and width helpers for the pipelined add/subtract unit.
package add_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } add_op_e;

   function automatic int max_w(int a, int b);
      return (a > b) ? a : b;
   endfunction

   // One extra bit holds the carry or borrow of a full-precision a +/- b.
   function automatic int sum_width(int wa, int wb);
      return max_w(wa, wb) + 1;
   endfunction

endpackage

// File: rtl/add_pipe_if.sv
// Operand and result streams of add_pipe.
// Handshake: a transfer happens on a rising edge where valid && ready; valid must
// not depend on ready, and payload is held stable while valid=1 and ready=0.
interface add_pipe_if #(
   parameter int WIDTH_A      = 32,
   parameter int WIDTH_B      = 4,
   parameter int RESULT_WIDTH = 33
);
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH_A-1:0]      a;
   logic [WIDTH_B-1:0]      b;
   logic                    op;
   logic                    out_valid;
   logic                    out_ready;
   logic [RESULT_WIDTH-1:0] result;
   logic                    overflow;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, overflow
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, overflow
   );
endinterface

// File: rtl/add_pipe_stage.sv
// One pipeline register slice: a valid bit plus a data word, loaded on enable.
module add_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);
   logic         valid_q;
   logic [W-1:0] data_q;

   // Take the upstream slice when this stage may move; reset discards contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (en_i) begin
         valid_q <= valid_i;
         data_q  <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
endmodule

// File: rtl/add_pipe.sv
// Pipelined add/subtract with valid/ready on both sides, optional signed mode,
// saturation or wrap on narrow results, and an overflow flag carried with the data.
// STAGES must lie in 1..8.
module add_pipe
   import add_pkg::*;
#(
   parameter int WIDTH_A      = 32,
   parameter int WIDTH_B      = 4,
   parameter int RESULT_WIDTH = 33,
   parameter int STAGES       = 2,
   parameter int SIGNED       = 0,
   parameter int SATURATE     = 0
) (
   input logic       clk,
   input logic       reset,
   add_pipe_if.slave bus
);
   localparam int SUM_W = sum_width(WIDTH_A, WIDTH_B);
   localparam int DW    = RESULT_WIDTH + 1;   // {overflow, result}

   add_op_e                 op_e;
   logic [SUM_W-1:0]        ext_a;
   logic [SUM_W-1:0]        ext_b;
   logic [SUM_W-1:0]        sum_full;
   logic [RESULT_WIDTH-1:0] res_d;
   logic                    ovf_d;
   logic [STAGES:0]         en;
   logic                    stage_v    [STAGES];
   logic [DW-1:0]           stage_data [STAGES];

   assign op_e = add_op_e'(bus.op);

   // Extend operands to full precision and form the exact sum or difference.
   always_comb begin
      ext_a = {SUM_W{(SIGNED != 0) && bus.a[WIDTH_A-1]}};
      ext_a[WIDTH_A-1:0] = bus.a;
      ext_b = {SUM_W{(SIGNED != 0) && bus.b[WIDTH_B-1]}};
      ext_b[WIDTH_B-1:0] = bus.b;
      sum_full = (op_e == OP_SUB) ? (ext_a - ext_b) : (ext_a + ext_b);
   end

   generate
      if (RESULT_WIDTH >= SUM_W) begin : g_extend
         // Every full-precision value fits, so just widen it.
         always_comb begin
            res_d = {RESULT_WIDTH{(SIGNED != 0) && sum_full[SUM_W-1]}};
            res_d[SUM_W-1:0] = sum_full;
            ovf_d = 1'b0;
         end
      end else begin : g_narrow
         logic [SUM_W-RESULT_WIDTH:0] hi;
         logic                        msb;
         logic                        fits;
         logic [RESULT_WIDTH-1:0]     sat_val;

         // Detect out-of-range values and choose clamp or wrap.
         // Unsigned: a set bit above the result range means too large, or,
         // for a subtract, a negative difference (MSB set) that clamps to 0.
         always_comb begin
            hi  = sum_full[SUM_W-1:RESULT_WIDTH-1];
            msb = sum_full[SUM_W-1];
            if (SIGNED != 0) begin
               fits    = (&hi) || !(|hi);
               sat_val = {RESULT_WIDTH{~msb}};
               sat_val[RESULT_WIDTH-1] = msb;
            end else begin
               fits    = !(|hi[SUM_W-RESULT_WIDTH:1]);
               sat_val = ((op_e == OP_SUB) && msb) ? '0 : '1;
            end
            ovf_d = !fits;
            res_d = ((SATURATE != 0) && !fits) ? sat_val : sum_full[RESULT_WIDTH-1:0];
         end
      end
   endgenerate

   // Ready chain: a stage may load when it is empty or the stage after it moves.
   always_comb begin
      en         = '0;
      en[STAGES] = bus.out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         en[i] = !stage_v[i] || en[i+1];
      end
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic          up_v;
      logic [DW-1:0] up_data;

      if (i == 0) begin : g_head
         assign up_v    = bus.in_valid;
         assign up_data = {ovf_d, res_d};
      end else begin : g_body
         assign up_v    = stage_v[i-1];
         assign up_data = stage_data[i-1];
      end

      add_pipe_stage #(.W(DW)) u_stage (
         .clk     (clk),
         .reset   (reset),
         .en_i    (en[i]),
         .valid_i (up_v),
         .data_i  (up_data),
         .valid_o (stage_v[i]),
         .data_o  (stage_data[i])
      );
   end

   assign bus.in_ready                 = en[0];
   assign bus.out_valid                = stage_v[STAGES-1];
   assign {bus.overflow, bus.result}   = stage_data[STAGES-1];
endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe: four configurations side by side, directed vectors with
// hand-computed results, back-pressure and mid-stream reset, then a random soak.
//   dut 0: defaults (32/4 -> 33, 2 stages, unsigned, wrap)
//   dut 1: 8/4 -> 8, 2 stages, signed, saturate
//   dut 2: 8/4 -> 8, 3 stages, unsigned, wrap
//   dut 3: 8/4 -> 8, 1 stage,  unsigned, saturate
module tb_add_pipe;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   bit   rnd_done;
   bit   stall2;
   logic [8:0] hold2;

   logic [33:0] q0 [$];
   logic [8:0]  q1 [$];
   logic [8:0]  q2 [$];
   logic [8:0]  q3 [$];

   logic [8:0] bp_exp [5] = '{9'd1, 9'd22, 9'd43, 9'd64, 9'd85};

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   add_pipe_if #(.WIDTH_A(32), .WIDTH_B(4), .RESULT_WIDTH(33)) if0 ();
   add_pipe_if #(.WIDTH_A(8),  .WIDTH_B(4), .RESULT_WIDTH(8))  if1 ();
   add_pipe_if #(.WIDTH_A(8),  .WIDTH_B(4), .RESULT_WIDTH(8))  if2 ();
   add_pipe_if #(.WIDTH_A(8),  .WIDTH_B(4), .RESULT_WIDTH(8))  if3 ();

   add_pipe #(.WIDTH_A(32), .WIDTH_B(4), .RESULT_WIDTH(33), .STAGES(2), .SIGNED(0), .SATURATE(0))
      u0 (.clk(clk), .reset(reset), .bus(if0));
   add_pipe #(.WIDTH_A(8), .WIDTH_B(4), .RESULT_WIDTH(8), .STAGES(2), .SIGNED(1), .SATURATE(1))
      u1 (.clk(clk), .reset(reset), .bus(if1));
   add_pipe #(.WIDTH_A(8), .WIDTH_B(4), .RESULT_WIDTH(8), .STAGES(3), .SIGNED(0), .SATURATE(0))
      u2 (.clk(clk), .reset(reset), .bus(if2));
   add_pipe #(.WIDTH_A(8), .WIDTH_B(4), .RESULT_WIDTH(8), .STAGES(1), .SIGNED(0), .SATURATE(1))
      u3 (.clk(clk), .reset(reset), .bus(if3));

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference result {overflow, result} from integer arithmetic.
   function automatic logic [33:0] model(input int d, input logic [31:0] a,
                                         input logic [3:0] b, input logic op);
      int     wa, rw, sw;
      bit     sgn, sat;
      longint av, bv, v, mx, mn, res;
      logic   ovf;
      wa  = (d == 0) ? 32 : 8;
      rw  = (d == 0) ? 33 : 8;
      sgn = (d == 1);
      sat = (d == 1) || (d == 3);
      sw  = wa + 1;
      av  = longint'(a) & ((longint'(1) << wa) - 1);
      bv  = longint'(b);
      if (sgn && av[wa-1]) av = av - (longint'(1) << wa);
      if (sgn && bv[3])    bv = bv - 16;
      v = op ? (av - bv) : (av + bv);
      if (rw >= sw) begin
         ovf = 1'b0;
         res = sgn ? v : (v & ((longint'(1) << sw) - 1));
      end else begin
         if (sgn) begin
            mx = (longint'(1) << (rw - 1)) - 1;
            mn = -(longint'(1) << (rw - 1));
         end else begin
            mx = (longint'(1) << rw) - 1;
            mn = 0;
         end
         ovf = (v > mx) || (v < mn);
         res = v;
         if (ovf && sat) res = (v > mx) ? mx : mn;
      end
      res = res & ((longint'(1) << rw) - 1);
      model = 34'(res);
      model[rw] = ovf;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_in(input int d, input logic v, input logic [31:0] a,
                         input logic [3:0] b, input logic op);
      case (d)
         0: begin if0.in_valid = v; if0.a = a;      if0.b = b; if0.op = op; end
         1: begin if1.in_valid = v; if1.a = a[7:0]; if1.b = b; if1.op = op; end
         2: begin if2.in_valid = v; if2.a = a[7:0]; if2.b = b; if2.op = op; end
         default: begin if3.in_valid = v; if3.a = a[7:0]; if3.b = b; if3.op = op; end
      endcase
   endtask

   function automatic logic ready_of(input int d);
      case (d)
         0: return if0.in_ready;
         1: return if1.in_ready;
         2: return if2.in_ready;
         default: return if3.in_ready;
      endcase
   endfunction

   task automatic push_exp(input int d, input logic [33:0] exp);
      case (d)
         0: q0.push_back(exp);
         1: q1.push_back(exp[8:0]);
         2: q2.push_back(exp[8:0]);
         default: q3.push_back(exp[8:0]);
      endcase
   endtask

   // Called and returns at posedge+1; expected value is queued at acceptance.
   task automatic send(input int d, input logic [31:0] a, input logic [3:0] b,
                       input logic op, input logic [33:0] exp);
      int t;
      bit acc;
      t   = 0;
      acc = 1'b0;
      set_in(d, 1'b1, a, b, op);
      while (!acc && t < 200) begin
         @(negedge clk);
         if (ready_of(d)) begin
            acc = 1'b1;
            push_exp(d, exp);
         end
         @(posedge clk);
         #1;
         t++;
      end
      set_in(d, 1'b0, 32'd0, 4'd0, 1'b0);
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout dut%0d: got no in_ready in 200 cycles, required acceptance", d);
      end
   endtask

   task automatic rand_stream(input int d, input int n);
      logic [31:0] a;
      logic [3:0]  b;
      logic        op;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 3))
            0:       a = 32'hFFFF_FFFF;
            1:       a = 32'd0;
            default: a = $urandom;
         endcase
         if (d != 0) a = {24'd0, a[7:0]};
         b  = 4'($urandom_range(0, 15));
         op = 1'($urandom_range(0, 1));
         while ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
         end
         send(d, a, b, op, model(d, a, b, op));
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic sb_pop(input int d, input logic [33:0] act);
      logic [33:0] exp;
      bit          empty;
      case (d)
         0: empty = (q0.size() == 0);
         1: empty = (q1.size() == 0);
         2: empty = (q2.size() == 0);
         default: empty = (q3.size() == 0);
      endcase
      checks++;
      if (empty) begin
         errors++;
         $display("FAIL sb%0d_extra: got output %h, required no output", d, act);
      end else begin
         case (d)
            0: exp = q0.pop_front();
            1: exp = {25'd0, q1.pop_front()};
            2: exp = {25'd0, q2.pop_front()};
            default: exp = {25'd0, q3.pop_front()};
         endcase
         if (act !== exp) begin
            errors++;
            $display("FAIL sb%0d_data: got %h expected %h", d, act, exp);
         end
      end
   endtask

   // Monitor: an output transfer completes at the next rising edge.
   always @(negedge clk) begin
      if (reset) begin
         stall2 = 1'b0;
      end else begin
         if (if0.out_valid && if0.out_ready) sb_pop(0, {if0.overflow, if0.result});
         if (if1.out_valid && if1.out_ready) sb_pop(1, {25'd0, if1.overflow, if1.result});
         if (if2.out_valid && if2.out_ready) sb_pop(2, {25'd0, if2.overflow, if2.result});
         if (if3.out_valid && if3.out_ready) sb_pop(3, {25'd0, if3.overflow, if3.result});
         if (stall2) chk("hold2", {24'd0, if2.out_valid, if2.overflow, if2.result}, {24'd0, 1'b1, hold2});
         stall2 = if2.out_valid && !if2.out_ready;
         hold2  = {if2.overflow, if2.result};
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int k;
      int drained;
      reset = 1'b1;
      for (int d = 0; d < 4; d++) set_in(d, 1'b0, 32'd0, 4'd0, 1'b0);
      if0.out_ready = 1'b1;
      if1.out_ready = 1'b1;
      if2.out_ready = 1'b1;
      if3.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid0",  34'(if0.out_valid), 34'd0);
      chk("rst_result0", 34'(if0.result),    34'd0);
      chk("rst_ovf0",    34'(if0.overflow),  34'd0);
      chk("rst_valid2",  34'(if2.out_valid), 34'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 34'({if0.in_ready, if1.in_ready, if2.in_ready, if3.in_ready}), 34'hF);
      @(posedge clk);
      #1;

      // Default config, exact latency of two cycles.
      send(0, 32'hFFFF_FFFF, 4'hF, 1'b0, 34'h1_0000_000E);
      @(negedge clk);
      chk("lat_cycle1", 34'(if0.out_valid), 34'd0);
      @(negedge clk);
      chk("lat_cycle2", 34'(if0.out_valid), 34'd1);
      @(posedge clk);
      #1;
      send(0, 32'd5, 4'd3, 1'b1, 34'd2);
      send(0, 32'd0, 4'd1, 1'b1, 34'h1_FFFF_FFFF);

      // Signed saturate, 8-bit result.
      send(1, 32'd100, 4'd7, 1'b0, 34'h06B);
      send(1, 32'h80,  4'd1, 1'b1, 34'h180);
      send(1, 32'h9C,  4'h8, 1'b0, 34'h094);
      send(1, 32'h7F,  4'd7, 1'b0, 34'h17F);
      send(1, 32'h00,  4'h8, 1'b1, 34'h008);

      // Unsigned wrap, 8-bit result.
      send(2, 32'd250, 4'd10, 1'b0, 34'h104);
      send(2, 32'd5,   4'd7,  1'b1, 34'h1FE);

      // Unsigned saturate, 8-bit result.
      send(3, 32'd3,   4'd5,  1'b1, 34'h100);
      send(3, 32'd250, 4'd10, 1'b0, 34'h1FF);
      send(3, 32'd15,  4'd15, 1'b1, 34'h000);
      send(3, 32'd255, 4'd0,  1'b0, 34'h0FF);
      repeat (6) @(posedge clk);
      #1;

      // Back-pressure on the 3-stage unit: 5 offered, 3 accepted.
      if2.out_ready = 1'b0;
      k = 0;
      set_in(2, 1'b1, 32'd1, 4'd0, 1'b0);
      repeat (6) begin
         @(negedge clk);
         if (if2.in_ready) begin
            q2.push_back(bp_exp[k]);
            k++;
         end
         @(posedge clk);
         #1;
         if (k < 5) set_in(2, 1'b1, 32'(1 + 20 * k), 4'(k), 1'b0);
         else       set_in(2, 1'b0, 32'd0, 4'd0, 1'b0);
      end
      chk("bp_accepted", 34'(k), 34'd3);
      @(negedge clk);
      chk("bp_in_ready",  34'(if2.in_ready),  34'd0);
      chk("bp_out_valid", 34'(if2.out_valid), 34'd1);
      chk("bp_head",      34'({if2.overflow, if2.result}), 34'h001);
      @(posedge clk);
      #1;
      if2.out_ready = 1'b1;
      drained = 0;
      repeat (5) begin
         @(negedge clk);
         if (if2.out_valid) drained++;
         if (if2.in_ready && if2.in_valid && k < 5) begin
            q2.push_back(bp_exp[k]);
            k++;
         end
         @(posedge clk);
         #1;
         if (k < 5) set_in(2, 1'b1, 32'(1 + 20 * k), 4'(k), 1'b0);
         else       set_in(2, 1'b0, 32'd0, 4'd0, 1'b0);
      end
      chk("bp_drain_rate",  34'(drained), 34'd5);
      chk("bp_all_accepted", 34'(k), 34'd5);
      repeat (4) @(posedge clk);
      #1;

      // Reset with two operations in flight.
      if0.out_ready = 1'b0;
      send(0, 32'd10, 4'd1, 1'b0, 34'd11);
      send(0, 32'd20, 4'd2, 1'b0, 34'd22);
      @(negedge clk);
      chk("pre_rst_valid", 34'(if0.out_valid), 34'd1);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_valid",  34'(if0.out_valid), 34'd0);
      chk("mid_rst_result", 34'(if0.result),    34'd0);
      q0.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      if0.out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("no_stale", 34'(if0.out_valid), 34'd0);
      end
      @(posedge clk);
      #1;

      // Random soak across all four configurations.
      rnd_done = 1'b0;
      fork
         begin
            fork
               rand_stream(0, 1000);
               rand_stream(1, 1000);
               rand_stream(2, 1000);
               rand_stream(3, 1000);
            join
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               if0.out_ready = 1'($urandom_range(0, 1));
               if1.out_ready = 1'($urandom_range(0, 1));
               if2.out_ready = 1'($urandom_range(0, 1));
               if3.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      if0.out_ready = 1'b1;
      if1.out_ready = 1'b1;
      if2.out_ready = 1'b1;
      if3.out_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("q0_empty", 34'(q0.size()), 34'd0);
      chk("q1_empty", 34'(q1.size()), 34'd0);
      chk("q2_empty", 34'(q2.size()), 34'd0);
      chk("q3_empty", 34'(q3.size()), 34'd0);

      // ---------------- report ----------------
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      errors++;
      $display("FAIL watchdog: got no completion by 900000 ns, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
